// File: rtl/esp32_prog_pkg.sv
// Shared types and constants for the ESP32 programming bridge: FSM encoding,
// the {en,io0} control patterns and the DTR/RTS-to-control mapping.
package esp32_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_BOOT = 2'd2,
    ST_PROG = 2'd3
  } state_e;

  localparam logic [1:0] PAIR_RUN  = 2'b11;
  localparam logic [1:0] PAIR_RST  = 2'b01;
  localparam logic [1:0] PAIR_BOOT = 2'b10;

  // {ndtr,nrts} as seen on the wire -> {en,io0}; both-asserted and
  // both-released leave the chip running, as the esptool auto-reset circuit does.
  function automatic logic [1:0] map_pair(input logic [1:0] pair);
    case (pair)
      2'b10:   map_pair = PAIR_RST;
      2'b01:   map_pair = PAIR_BOOT;
      default: map_pair = PAIR_RUN;
    endcase
  endfunction

endpackage

// File: rtl/esp32_prog_bridge_sync_filter.sv
// Multi-flop synchroniser followed by a stability filter: the output takes a
// new value only once the synchronised input has held it FILTER_LEN cycles.
module sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 16,
  parameter int unsigned WIDTH       = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;
  logic [WIDTH-1:0]                  cand_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CNT_W-1:0]                  cnt_next;

  assign synced = sync_q[SYNC_STAGES-1];

  // Count includes the current cycle, so FILTER_LEN=1 accepts immediately.
  always_comb begin
    cnt_next = CNT_W'(1);
    if (synced == cand_q) begin
      cnt_next = (cnt_q == CNT_W'(FILTER_LEN)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset loads the deasserted (all-ones) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      cand_q <= '1;
      cnt_q  <= '0;
      o_q    <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      cand_q <= synced;
      cnt_q  <= cnt_next;
      if (cnt_next == CNT_W'(FILTER_LEN)) o_q <= synced;
    end
  end

endmodule

// File: rtl/esp32_prog_bridge.sv
// FTDI-to-ESP32 programming bridge: UART passthrough plus DTR/RTS auto-reset
// decoding, with a session FSM that releases after a period of UART silence.
module esp32_prog_bridge
  import esp32_prog_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 16,
  parameter int unsigned RELEASE_W   = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ftdi_ndtr,
  input  logic       i_ftdi_nrts,
  input  logic       i_ftdi_txd,
  input  logic       i_wifi_txd,
  input  logic       i_btn_boot_n,
  output logic       o_ftdi_rxd,
  output logic       o_wifi_rxd,
  output logic       o_wifi_en,
  output logic       o_wifi_gpio0,
  output logic       o_prog_active,
  output logic [1:0] o_state
);

  logic [1:0]                  pair_filt;
  logic [SYNC_STAGES-1:0][2:0] plain_q;
  logic [2:0]                  plain_s;
  logic [1:0]                  txd_prev_q;
  logic                        activity;
  logic [1:0]                  map_q;
  state_e                      state_q;
  state_e                      state_next;
  logic [RELEASE_W-1:0]        rel_cnt_q;
  logic                        timeout;
  logic                        prog_active_q;

  assign o_ftdi_rxd = i_wifi_txd;
  assign o_wifi_rxd = i_ftdi_txd;

  sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .WIDTH      (2)
  ) u_pair_filter (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    ({i_ftdi_ndtr, i_ftdi_nrts}),
    .o_q    (pair_filt)
  );

  // Button and TXD lines only need metastability protection, not debouncing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      plain_q    <= '1;
      txd_prev_q <= '1;
    end else begin
      plain_q    <= {plain_q[SYNC_STAGES-2:0], {i_btn_boot_n, i_ftdi_txd, i_wifi_txd}};
      txd_prev_q <= plain_s[1:0];
    end
  end

  assign plain_s  = plain_q[SYNC_STAGES-1];
  assign activity = |(plain_s[1:0] ^ txd_prev_q);
  assign timeout  = rel_cnt_q[RELEASE_W-1];

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (map_q == PAIR_RST) state_next = ST_RST;
      ST_RST: begin
        if      (map_q == PAIR_BOOT) state_next = ST_BOOT;
        else if (map_q == PAIR_RUN)  state_next = ST_IDLE;
      end
      ST_BOOT: begin
        if      (map_q == PAIR_RUN) state_next = ST_PROG;
        else if (map_q == PAIR_RST) state_next = ST_RST;
      end
      ST_PROG: begin
        // A host reset request beats a timeout; live traffic beats a timeout.
        if      (map_q == PAIR_RST)     state_next = ST_RST;
        else if (!activity && timeout)  state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      map_q         <= PAIR_RUN;
      state_q       <= ST_IDLE;
      prog_active_q <= 1'b0;
    end else begin
      map_q         <= map_pair(pair_filt);
      state_q       <= state_next;
      prog_active_q <= (state_next == ST_BOOT) || (state_next == ST_PROG);
    end
  end

  // Silence counter: saturates once the MSB is reached so the timeout holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rel_cnt_q <= '0;
    end else if (state_q != ST_PROG) begin
      if (state_next == ST_PROG) rel_cnt_q <= '0;
    end else if (activity) begin
      rel_cnt_q <= '0;
    end else if (!timeout) begin
      rel_cnt_q <= rel_cnt_q + 1'b1;
    end
  end

  assign o_wifi_en     = map_q[1];
  assign o_wifi_gpio0  = map_q[0] & plain_s[2];
  assign o_prog_active = prog_active_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_esp32_prog_bridge.sv
// Scoreboard bench for esp32_prog_bridge: a history-based reference model
// predicts each output change and its cycle; a monitor compares DUT changes.
module tb_esp32_prog_bridge;

  localparam int S    = 2;
  localparam int F    = 4;
  localparam int RW   = 6;
  localparam int TMO  = 1 << (RW - 1);
  localparam int MAXC = 8000;
  localparam logic [4:0] RESET_TUP = 5'b11000;

  typedef struct {
    logic [4:0] tup;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ndtr = 1'b1, nrts = 1'b1, ftdi_txd = 1'b1, wifi_txd = 1'b1, btn_n = 1'b1;
  logic ftdi_rxd, wifi_rxd, wifi_en, wifi_gpio0, prog_active;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r0 = 1 << 30;

  logic [1:0] pair_h [MAXC];
  logic       btn_h  [MAXC];
  logic       ft_h   [MAXC];
  logic       wt_h   [MAXC];

  logic [1:0] m_filt = 2'b11;
  logic [1:0] m_map = 2'b11;
  logic [1:0] m_state = 2'd0;
  int         m_mark = 0;
  logic [4:0] m_last = RESET_TUP;
  exp_t       exp_q[$];

  esp32_prog_bridge #(
    .SYNC_STAGES(S),
    .FILTER_LEN (F),
    .RELEASE_W  (RW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ftdi_ndtr  (ndtr),
    .i_ftdi_nrts  (nrts),
    .i_ftdi_txd   (ftdi_txd),
    .i_wifi_txd   (wifi_txd),
    .i_btn_boot_n (btn_n),
    .o_ftdi_rxd   (ftdi_rxd),
    .o_wifi_rxd   (wifi_rxd),
    .o_wifi_en    (wifi_en),
    .o_wifi_gpio0 (wifi_gpio0),
    .o_prog_active(prog_active),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Value the synchroniser presents after edge j: the input sampled S-1 edges
  // earlier, or the reset level if that sample predates reset release.
  function automatic logic [1:0] sp(input int j);
    int i = j - S + 1;
    if (i < r0 || i < 0) return 2'b11;
    return pair_h[i];
  endfunction

  function automatic logic hb(input int sel, input int j);
    int i = j - S + 1;
    if (i < r0 || i < 0) return 1'b1;
    case (sel)
      0:       return btn_h[i];
      1:       return ft_h[i];
      default: return wt_h[i];
    endcase
  endfunction

  function automatic logic [1:0] map_ref(input logic [1:0] p);
    case (p)
      2'b11:   return 2'b11;
      2'b00:   return 2'b11;
      2'b10:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [4:0] cur_tup();
    return {wifi_en, wifi_gpio0, prog_active, state};
  endfunction

  task automatic push_if_changed(input logic [4:0] tup, input int at);
    exp_t e;
    if (tup != m_last) begin
      e.tup = tup;
      e.cyc = at;
      exp_q.push_back(e);
      m_last = tup;
    end
  endtask

  // Reference model, evaluated once per rising edge.
  initial begin
    int k;
    logic act, stable;
    forever begin
      @(posedge clk);
      cyc++;
      pair_h[cyc] = {ndtr, nrts};
      btn_h[cyc]  = btn_n;
      ft_h[cyc]   = ftdi_txd;
      wt_h[cyc]   = wifi_txd;
      if (!rst_n) begin
        r0 = cyc + 1;
      end else begin
        k = cyc;
        act = (hb(1, k-1) != hb(1, k-2)) || (hb(2, k-1) != hb(2, k-2));
        case (m_state)
          2'd0: if (m_map == 2'b01) m_state = 2'd1;
          2'd1: begin
            if (m_map == 2'b10) m_state = 2'd2;
            else if (m_map == 2'b11) m_state = 2'd0;
          end
          2'd2: begin
            if (m_map == 2'b11) begin m_state = 2'd3; m_mark = k; end
            else if (m_map == 2'b01) m_state = 2'd1;
          end
          default: begin
            if (m_map == 2'b01) m_state = 2'd1;
            else if (act) m_mark = k;
            else if (k - m_mark > TMO) m_state = 2'd0;
          end
        endcase
        m_map = map_ref(m_filt);
        stable = (k - F + 1 >= r0);
        for (int m = k - F + 1; m < k; m++) if (sp(m - 1) != sp(k - 1)) stable = 1'b0;
        if (stable) m_filt = sp(k - 1);
        push_if_changed({m_map[1], m_map[0] & hb(0, k), m_state >= 2'd2, m_state}, k);
      end
    end
  end

  // Monitor: samples after outputs settle, pops one expectation per change.
  initial begin
    logic [4:0] last = RESET_TUP;
    logic [4:0] cur;
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      check("passthru_ftdi_rxd", ftdi_rxd, wifi_txd);
      check("passthru_wifi_rxd", wifi_rxd, ftdi_txd);
      cur = cur_tup();
      if (cur !== last) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change actual=%b required=%b cycle=%0d", cur, last, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_tuple", cur, e.tup);
          check("out_cycle", cyc, e.cyc);
        end
        last = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic drive_pair(input logic [1:0] p, input int n);
    @(negedge clk);
    {ndtr, nrts} = p;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_in_session();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push_if_changed(RESET_TUP, cyc);
    m_state = 2'd0;
    m_map   = 2'b11;
    m_filt  = 2'b11;
    r0      = 1 << 30;
    #1;
    check("rst_en", wifi_en, 1'b1);
    check("rst_gpio0", wifi_gpio0, 1'b1);
    check("rst_prog_active", prog_active, 1'b0);
    check("rst_state", state, 2'd0);
    #1;
    ftdi_txd = ~ftdi_txd;
    wifi_txd = ~wifi_txd;
    #1;
    check("rst_passthru_wifi_rxd", wifi_rxd, ftdi_txd);
    check("rst_passthru_ftdi_rxd", ftdi_rxd, wifi_txd);
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_tuple", cur_tup(), RESET_TUP);
    idle(3);
    rst_n = 1'b1;
    drive_pair(2'b11, 12);

    // Each pair accepted after S+F+1 cycles; 00 lands in PROG and times out.
    drive_pair(2'b11, 10);
    drive_pair(2'b10, 10);
    drive_pair(2'b01, 10);
    drive_pair(2'b00, 10);
    drive_pair(2'b11, 50);

    // Glitch shorter than the filter must not disturb anything.
    drive_pair(2'b10, 3);
    drive_pair(2'b11, 20);
    check("glitch_state", state, 2'd0);
    check("glitch_en_io0", {wifi_en, wifi_gpio0}, 2'b11);

    // esptool auto-reset sequence with random hold times.
    drive_pair(2'b10, $urandom_range(8, 15));
    drive_pair(2'b01, $urandom_range(8, 15));
    drive_pair(2'b11, $urandom_range(8, 15));
    idle(4);
    check("esptool_state", state, 2'd3);
    check("esptool_prog_active", prog_active, 1'b1);
    idle(50);
    check("timeout_state", state, 2'd0);
    check("timeout_prog_active", prog_active, 1'b0);

    // UART traffic keeps the session alive.
    drive_pair(2'b10, 10);
    drive_pair(2'b01, 10);
    drive_pair(2'b11, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ftdi_txd = ~ftdi_txd;
      idle(19);
      check("traffic_state", state, 2'd3);
    end
    idle(60);
    check("traffic_release_state", state, 2'd0);

    // Boot button pulls IO0 low without touching EN or the FSM.
    @(negedge clk);
    btn_n = 1'b0;
    idle(5);
    check("btn_gpio0", wifi_gpio0, 1'b0);
    check("btn_en", wifi_en, 1'b1);
    check("btn_state", state, 2'd0);
    btn_n = 1'b1;
    idle(5);

    // Reset in the middle of a session.
    drive_pair(2'b10, 10);
    drive_pair(2'b01, 10);
    drive_pair(2'b11, 10);
    idle(4);
    reset_in_session();
    idle(20);

    // Random segments: pairs, hold lengths, UART edges and button presses.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) wifi_txd = ~wifi_txd;
      if ($urandom_range(0, 4) == 0) ftdi_txd = ~ftdi_txd;
      btn_n = ($urandom_range(0, 7) != 0);
      drive_pair(2'($urandom_range(0, 3)), $urandom_range(1, 14));
    end
    btn_n = 1'b1;
    drive_pair(2'b11, 60);

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
